// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush generator for a 5-stage pipeline: arbitrates D-miss, mispredict,
// load-use and I-miss hazards, tracks miss duration, runs a miss watchdog and perf counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int MISS_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_mispredict,
  input  logic             icache_miss,
  input  logic             icache_ready,
  input  logic             dcache_miss,
  input  logic             dcache_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_stall,
  output logic             redirect_valid,
  output logic             err_timeout,
  output logic [CNT_W-1:0] perf_dmiss_cyc,
  output logic [CNT_W-1:0] perf_imiss_cyc,
  output logic [CNT_W-1:0] perf_loaduse,
  output logic [CNT_W-1:0] perf_flush
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    IMISS = 2'd2
  } state_t;

  localparam int WD_W = $clog2(MISS_TIMEOUT + 1);

  state_t          state;
  state_t          state_nxt;
  logic [WD_W-1:0] wdog;

  logic dmiss_active;
  logic imiss_active;
  logic load_use;
  logic take_mispredict;
  logic take_loaduse;
  logic take_imiss;

  assign dmiss_active    = dcache_miss & ~dcache_ready;
  assign imiss_active    = icache_miss & ~icache_ready;
  assign load_use        = ex_mem_read & (ex_rd != 5'd0) &
                           ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign take_mispredict = mem_mispredict & ~dmiss_active;
  assign take_loaduse    = load_use & ~dmiss_active & ~mem_mispredict;
  assign take_imiss      = imiss_active & ~dmiss_active & ~mem_mispredict;

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_stall   = 1'b0;
    ex_mem_flush   = 1'b0;
    mem_wb_stall   = 1'b0;
    redirect_valid = 1'b0;
    if (rst_n) begin
      if (dmiss_active) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if (take_mispredict) begin
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        ex_mem_flush   = 1'b1;
        redirect_valid = 1'b1;
      end else if (take_loaduse) begin
        // A concurrent I-miss is absorbed: holding IF/ID keeps the dependent instruction.
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (take_imiss) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (dmiss_active)      state_nxt = DMISS;
        else if (imiss_active) state_nxt = IMISS;
      end
      DMISS: begin
        if (dcache_ready) state_nxt = imiss_active ? IMISS : RUN;
      end
      IMISS: begin
        if (dmiss_active)      state_nxt = DMISS;
        else if (icache_ready) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Watchdog saturates at MISS_TIMEOUT; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else if (state == RUN) begin
      wdog <= '0;
    end else begin
      if (wdog != WD_W'(MISS_TIMEOUT)) wdog <= wdog + WD_W'(1);
      if (wdog == WD_W'(MISS_TIMEOUT - 1)) err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dmiss_cyc <= '0;
      perf_imiss_cyc <= '0;
      perf_loaduse   <= '0;
      perf_flush     <= '0;
    end else begin
      if (state == DMISS)  perf_dmiss_cyc <= perf_dmiss_cyc + CNT_W'(1);
      if (state == IMISS)  perf_imiss_cyc <= perf_imiss_cyc + CNT_W'(1);
      if (take_loaduse)    perf_loaduse   <= perf_loaduse + CNT_W'(1);
      if (take_mispredict) perf_flush     <= perf_flush + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic checked against
// a rule-level model of the hazard priorities, miss tracking, watchdog and counters.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 8;
  localparam int TMO   = 8;

  // Control vector bit order: pc, if_id_st, if_id_fl, id_ex_st, id_ex_fl,
  // ex_mem_st, ex_mem_fl, mem_wb_st, redirect
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_DM   = 9'b110101010;
  localparam logic [8:0] C_MP   = 9'b001010101;
  localparam logic [8:0] C_LU   = 9'b110010000;
  localparam logic [8:0] C_IM   = 9'b101000000;

  localparam int M_RUN   = 0;
  localparam int M_DMISS = 1;
  localparam int M_IMISS = 2;

  logic clk;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_mem_read, mem_mispredict;
  logic icache_miss, icache_ready, dcache_miss, dcache_ready;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_stall, redirect_valid, err_timeout;
  logic [CNT_W-1:0] perf_dmiss_cyc, perf_imiss_cyc, perf_loaduse, perf_flush;
  logic [8:0] ctl;

  int checks;
  int errors;

  // Reference model state
  int               m_mode;
  int               m_run;
  logic             m_err;
  logic [CNT_W-1:0] m_dmc, m_imc, m_lu, m_fl;

  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, ex_mem_flush, mem_wb_stall, redirect_valid};

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MISS_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .mem_mispredict (mem_mispredict),
    .icache_miss    (icache_miss),
    .icache_ready   (icache_ready),
    .dcache_miss    (dcache_miss),
    .dcache_ready   (dcache_ready),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_stall    (id_ex_stall),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_stall   (ex_mem_stall),
    .ex_mem_flush   (ex_mem_flush),
    .mem_wb_stall   (mem_wb_stall),
    .redirect_valid (redirect_valid),
    .err_timeout    (err_timeout),
    .perf_dmiss_cyc (perf_dmiss_cyc),
    .perf_imiss_cyc (perf_imiss_cyc),
    .perf_loaduse   (perf_loaduse),
    .perf_flush     (perf_flush)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic is_load_use();
    return ex_mem_read && (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  // Expected control vector from the priority rules: dmiss > mispredict > load-use > imiss.
  function automatic logic [8:0] model_ctl();
    logic dm, im, lu;
    dm = dcache_miss && !dcache_ready;
    im = icache_miss && !icache_ready;
    lu = is_load_use();
    if (!rst_n)          return C_NONE;
    if (dm)              return C_DM;
    if (mem_mispredict)  return C_MP;
    if (lu)              return C_LU;
    if (im)              return C_IM;
    return C_NONE;
  endfunction

  task automatic model_clear();
    m_mode = M_RUN;
    m_run  = 0;
    m_err  = 1'b0;
    m_dmc  = '0;
    m_imc  = '0;
    m_lu   = '0;
    m_fl   = '0;
  endtask

  task automatic model_update();
    logic dm, im;
    dm = dcache_miss && !dcache_ready;
    im = icache_miss && !icache_ready;
    if (m_mode == M_DMISS) m_dmc = m_dmc + 1'b1;
    if (m_mode == M_IMISS) m_imc = m_imc + 1'b1;
    if (!dm && mem_mispredict)     m_fl = m_fl + 1'b1;
    else if (!dm && is_load_use()) m_lu = m_lu + 1'b1;
    if (m_mode == M_RUN) m_run = 0;
    else                 m_run = m_run + 1;
    if (m_run >= TMO) m_err = 1'b1;
    case (m_mode)
      M_RUN:   m_mode = dm ? M_DMISS : (im ? M_IMISS : M_RUN);
      M_DMISS: if (dcache_ready) m_mode = im ? M_IMISS : M_RUN;
      default: m_mode = dm ? M_DMISS : (icache_ready ? M_RUN : M_IMISS);
    endcase
  endtask

  // Driver tasks
  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; mem_mispredict = 1'b0;
    icache_miss = 1'b0; icache_ready = 1'b0;
    dcache_miss = 1'b0; dcache_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_clear();
    dcache_miss = 1'b1;
    mem_mispredict = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_NONE) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE);
    end
    checks++;
    if ({err_timeout, perf_dmiss_cyc, perf_imiss_cyc, perf_loaduse, perf_flush} !== '0) begin
      errors++; $display("FAIL reset_regs: err=%b dm=%0d im=%0d lu=%0d fl=%0d want all 0",
                         err_timeout, perf_dmiss_cyc, perf_imiss_cyc, perf_loaduse, perf_flush);
    end
    tick();
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5;
    @(negedge clk);
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL loaduse_ctl: got %b want %b", ctl, C_LU); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (perf_loaduse !== 8'd1) begin
      errors++; $display("FAIL loaduse_cnt: got %0d want 1", perf_loaduse);
    end
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    @(negedge clk);
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL loaduse_x0: got %b want %b", ctl, C_NONE); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (perf_loaduse !== 8'd1) begin
      errors++; $display("FAIL loaduse_x0_cnt: got %0d want 1", perf_loaduse);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    mem_mispredict = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    @(negedge clk);
    checks++;
    if (ctl !== C_MP) begin errors++; $display("FAIL mispredict_ctl: got %b want %b", ctl, C_MP); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (ctl !== C_NONE || perf_flush !== 8'd1 || perf_loaduse !== 8'd0) begin
      errors++; $display("FAIL mispredict_after: ctl=%b fl=%0d lu=%0d want %b 1 0",
                         ctl, perf_flush, perf_loaduse, C_NONE);
    end
  endtask

  task automatic test_dmiss();
    do_reset();
    dcache_miss = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      dcache_ready = (i == 5);
      @(negedge clk);
      checks++;
      if (ctl !== ((i < 5) ? C_DM : C_NONE)) begin
        errors++; $display("FAIL dmiss_ctl[%0d]: got %b want %b", i, ctl, (i < 5) ? C_DM : C_NONE);
      end
      tick();
    end
    clear_inputs();
    icache_miss = 1'b1;
    @(negedge clk);
    checks++;
    if (perf_dmiss_cyc !== 8'd4 || ctl !== C_IM) begin
      errors++; $display("FAIL dmiss_end: cyc=%0d ctl=%b want 4 %b", perf_dmiss_cyc, ctl, C_IM);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (perf_imiss_cyc !== 8'd0 || perf_dmiss_cyc !== 8'd4) begin
      errors++; $display("FAIL dmiss_run_after: im=%0d dm=%0d want 0 4", perf_imiss_cyc, perf_dmiss_cyc);
    end
  endtask

  task automatic test_dmiss_pending();
    do_reset();
    dcache_miss = 1'b1; mem_mispredict = 1'b1; icache_miss = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      dcache_ready = (i == 3);
      @(negedge clk);
      checks++;
      if (ctl !== ((i < 3) ? C_DM : C_MP)) begin
        errors++; $display("FAIL pend_ctl[%0d]: got %b want %b", i, ctl, (i < 3) ? C_DM : C_MP);
      end
      tick();
    end
    dcache_miss = 1'b0; dcache_ready = 1'b0; mem_mispredict = 1'b0;
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9;
    @(negedge clk);
    checks++;
    if (ctl !== C_LU || perf_flush !== 8'd1) begin
      errors++; $display("FAIL pend_lu_imiss: ctl=%b fl=%0d want %b 1", ctl, perf_flush, C_LU);
    end
    tick();
    clear_inputs();
    icache_miss = 1'b1;
    @(negedge clk);
    checks++;
    if (perf_imiss_cyc !== 8'd1) begin
      errors++; $display("FAIL pend_state_imiss: imiss_cyc=%0d want 1", perf_imiss_cyc);
    end
    icache_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    icache_miss = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (err_timeout !== (i >= 10)) begin
        errors++; $display("FAIL wdog[%0d]: got %b want %b", i, err_timeout, (i >= 10));
      end
      tick();
    end
    icache_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b1 || perf_imiss_cyc !== 8'd20) begin
      errors++; $display("FAIL wdog_sticky: err=%b imiss=%0d want 1 20", err_timeout, perf_imiss_cyc);
    end
  endtask

  task automatic test_reset_mid_dmiss();
    dcache_miss = 1'b1;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (ctl !== C_NONE || err_timeout !== 1'b0 || perf_dmiss_cyc !== 8'd0 || perf_imiss_cyc !== 8'd0) begin
      errors++; $display("FAIL rst_mid: ctl=%b err=%b dm=%0d im=%0d want 0",
                         ctl, err_timeout, perf_dmiss_cyc, perf_imiss_cyc);
    end
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== C_DM) begin errors++; $display("FAIL rst_newmiss: got %b want %b", ctl, C_DM); end
    tick(); tick();
    @(negedge clk);
    checks++;
    if (perf_dmiss_cyc !== 8'd1) begin
      errors++; $display("FAIL rst_newmiss_cnt: got %0d want 1", perf_dmiss_cyc);
    end
    dcache_ready = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    dcache_miss = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    @(negedge clk);
    checks++;
    if (perf_dmiss_cyc !== 8'd3 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL wrap: dm=%0d err=%b want 3 1", perf_dmiss_cyc, err_timeout);
    end
    dcache_ready = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      dcache_miss    = ($urandom_range(0, 3) == 0);
      dcache_ready   = ($urandom_range(0, 3) == 0);
      icache_miss    = ($urandom_range(0, 2) == 0);
      icache_ready   = ($urandom_range(0, 3) == 0);
      mem_mispredict = ($urandom_range(0, 5) == 0);
      ex_mem_read    = ($urandom_range(0, 1) == 0);
      ex_rd          = 5'($urandom_range(0, 3));
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if (ctl !== model_ctl()) begin
        errors++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, ctl, model_ctl());
      end
      checks++;
      if ({perf_dmiss_cyc, perf_imiss_cyc, perf_loaduse, perf_flush, err_timeout} !==
          {m_dmc, m_imc, m_lu, m_fl, m_err}) begin
        errors++; $display("FAIL rand_regs[%0d]: got dm=%0d im=%0d lu=%0d fl=%0d err=%b want %0d %0d %0d %0d %b",
                           i, perf_dmiss_cyc, perf_imiss_cyc, perf_loaduse, perf_flush, err_timeout,
                           m_dmc, m_imc, m_lu, m_fl, m_err);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    model_clear();
    #1;
    test_reset();
    test_load_use();
    test_mispredict();
    test_dmiss();
    test_dmiss_pending();
    test_watchdog();
    test_reset_mid_dmiss();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush generator that drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. It arbitrates four hazard sources:
- D-cache miss (freezes the whole pipe)
- branch misprediction resolved in MEM (flushes younger stages)
- load-use dependency (one bubble)
- I-cache miss (bubbles into ID)

It tracks miss duration with an FSM, runs a miss watchdog, and keeps performance counters.

Parameters:
- CNT_W, 32, width of each performance counter (wraps modulo 2^CNT_W).
- MISS_TIMEOUT, 1024, cycles in a miss state before err_timeout sets.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- ex_rd  in  5  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- mem_mispredict  in  1  branch/jump in MEM resolved against its prediction.
- icache_miss  in  1  level; fetch miss outstanding.
- icache_ready  in  1  pulse; fill done, instruction valid this cycle.
- dcache_miss  in  1  level; MEM-stage access miss outstanding.
- dcache_ready  in  1  pulse; data valid this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  to IF/ID stall.
- if_id_flush  out  1  to IF/ID flush.
- id_ex_stall  out  1  to ID/EX stall.
- id_ex_flush  out  1  to ID/EX flush.
- ex_mem_stall  out  1  to EX/MEM stall.
- ex_mem_flush  out  1  to EX/MEM flush.
- mem_wb_stall  out  1  to MEM/WB stall.
- redirect_valid  out  1  fetch takes the corrected PC this cycle.
- err_timeout  out  1  sticky watchdog error.
- perf_dmiss_cyc  out  CNT_W  cycles spent in DMISS.
- perf_imiss_cyc  out  CNT_W  cycles spent in IMISS.
- perf_loaduse  out  CNT_W  load-use bubbles inserted.
- perf_flush  out  CNT_W  mispredict flushes performed.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- While rst_n=0:
  - state=RUN, all counters 0, err_timeout=0, watchdog=0.
  - All stall, flush and redirect outputs are 0.
- Control outputs are combinational from state and inputs (zero-cycle latency). Counters, state and watchdog are registered.
- FSM states: RUN, DMISS, IMISS.
- FSM transitions:
  - RUN: dcache_miss & !dcache_ready -> DMISS; else icache_miss & !icache_ready -> IMISS.
  - DMISS: on dcache_ready, go to IMISS if icache_miss & !icache_ready, else RUN.
  - IMISS: dcache_miss & !dcache_ready -> DMISS (D has priority); else icache_ready -> RUN.
- dmiss_active = dcache_miss & !dcache_ready (any state). While active:
  - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_stall are all 1.
  - All flushes are 0 and redirect_valid=0.
  - mem_mispredict and load-use are ignored; they persist because the pipe is frozen.
- Mispredict (mem_mispredict & !dmiss_active):
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, redirect_valid=1, for one cycle.
  - Overrides load-use and I-miss handling.
  - perf_flush increments.
- Load-use (ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2), with no dmiss and no mispredict):
  - pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - perf_loaduse increments once per bubble cycle.
- I-miss (imiss_active = icache_miss & !icache_ready), when none of the above apply:
  - pc_stall=1, if_id_flush=1 (NOP into ID).
  - If load-use coincides: if_id_stall=1 and if_id_flush=0, so the dependent instruction is kept.
- Priority order: dmiss > mispredict > load-use > imiss.
- A mispredict during IMISS leaves the state in IMISS; the fill completes normally.
- Counters:
  - perf_dmiss_cyc increments each cycle state==DMISS.
  - perf_imiss_cyc increments each cycle state==IMISS.
  - All counters wrap to 0 on overflow.
- Watchdog:
  - Counts consecutive cycles in DMISS/IMISS and clears in RUN.
  - On reaching MISS_TIMEOUT, err_timeout=1 (sticky until reset). The FSM keeps waiting.
- Reset mid-miss: state is immediately RUN and outputs are 0. Miss inputs still high after reset release are treated as new misses.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 for 1 cycle -> same cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; perf_loaduse=1. Repeating with ex_rd=0 -> no stall.
- Mispredict: mem_mispredict=1 for 1 cycle -> if_id_flush, id_ex_flush, ex_mem_flush, redirect_valid all 1 for exactly that cycle; perf_flush=1; mem_wb_stall=0.
- D-miss: dcache_miss high 5 cycles, dcache_ready on the 5th -> all five stalls 1 for 4 cycles, 0 on the ready cycle; perf_dmiss_cyc=4; state RUN after.
- D-miss with pending mispredict and I-miss: mem_mispredict=1 and icache_miss=1 throughout a 3-cycle D-miss -> no flush during the miss; flush+redirect on the ready cycle; next state IMISS; if_id_flush is not asserted while load-use holds.
- Watchdog: MISS_TIMEOUT=8, icache_miss held 20 cycles -> err_timeout rises after 8 IMISS cycles and stays 1 after icache_ready.
- Reset mid-DMISS: rst_n low for 2 cycles during a miss -> outputs 0 asynchronously, counters 0, err_timeout 0.
